// File: rtl/mcu_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mcu_tx_arbiter
//
// Round-robin arbiter that shares the single NDN->MCU SPI transmit path
// between NUM_REQ requesters (e.g. PIT data return, content-store hits).
// A transaction grants one requester, pulses spi_start for one cycle, streams
// DATA_BYTES bytes from that requester into the transmitter, and then holds
// the grant for TX_CYCLES more cycles while the transmitter serialises the
// 64-bit prefix and the data. After that, priority rotates past the requester
// that was just served.
//
// Ports
//   clk           system clock, all logic on posedge
//   rst           asynchronous, active-high reset
//   req_valid     per-requester "packet ready" level
//   req_prefix    64-bit prefix per requester, slice [64*i +: 64]
//   req_data      current data byte per requester, slice [8*i +: 8]
//   req_grant     one-hot grant, held for the whole transaction
//   req_data_ack  per-requester pulse on each cycle one of its bytes is consumed
//   spi_start     one-cycle start pulse to the SPI transmitter
//   spi_data      byte to the transmitter (granted requester's req_data)
//   spi_prefix    granted requester's prefix while busy, else 0
//   busy          high from START through the end of DRAIN
//   last_grant    index of the most recently completed grant
// -----------------------------------------------------------------------------
module mcu_tx_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int IDX_W      = 1,
    parameter int DATA_BYTES = 32,
    parameter int TX_CYCLES  = 322,
    parameter int CNT_W      = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [64*NUM_REQ-1:0] req_prefix,
    input  logic [8*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]    req_grant,
    output logic [NUM_REQ-1:0]    req_data_ack,
    output logic                  spi_start,
    output logic [7:0]            spi_data,
    output logic [63:0]           spi_prefix,
    output logic                  busy,
    output logic [IDX_W-1:0]      last_grant
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM,
        DRAIN
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   g;        // index of the requester currently granted
    logic [CNT_W-1:0]   cnt;      // bytes left in STREAM, cycles left in DRAIN
    logic [IDX_W-1:0]   next_g;   // round-robin winner among current requests

    // Round-robin pick: scan last_grant+1, last_grant+2, ... wrapping modulo
    // NUM_REQ, so the requester served last has the lowest priority.
    always_comb begin
        int  idx;
        logic found;
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        next_g = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                next_g = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // NOTE: all state here updates with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            g          <= '0;
            cnt        <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);  // so requester 0 wins first
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        g     <= next_g;
                        state <= START;
                    end
                end
                START: begin
                    // Byte 0 is consumed here; the rest follow in STREAM.
                    if (DATA_BYTES == 1) begin
                        cnt   <= CNT_W'(TX_CYCLES);
                        state <= DRAIN;
                    end else begin
                        cnt   <= CNT_W'(DATA_BYTES - 1);
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt   <= CNT_W'(TX_CYCLES);
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DRAIN: begin
                    // Grant is held until the transmitter has finished
                    // serialising; only then does priority rotate.
                    if (cnt == CNT_W'(1)) begin
                        cnt        <= '0;
                        last_grant <= g;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from state and g, so a reset clears them in
    // the same cycle it is asserted.
    always_comb begin
        logic [NUM_REQ-1:0] g_oh;
        int                 gi;
        gi           = int'(g);
        g_oh         = NUM_REQ'(1) << g;
        busy         = (state != IDLE);
        spi_start    = (state == START);
        req_grant    = busy ? g_oh : '0;
        req_data_ack = (state == START || state == STREAM) ? g_oh : '0;
        spi_data     = busy ? req_data[8*gi +: 8]    : 8'd0;
        spi_prefix   = busy ? req_prefix[64*gi +: 64] : 64'd0;
    end

endmodule
